fwd_sel_unit: RTL and testbench

- Operand-select controller that drives the 2-bit `sel` inputs of the two ALU operand 4:1 muxes in the execute stage.
- Tracks destination registers through the EX, MEM and WB pipeline slots and resolves RAW hazards by forwarding.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion.
- Sits between decode and the execute-stage operand muxes.

---
 rtl/fwd_sel_unit.sv | 125 ++++++++++++
 tb/tb_fwd_sel_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_sel_unit.sv
// Execute-stage operand-select and load-use hazard controller.
// Tracks EX/MEM/WB destination registers and drives the ALU operand mux selects.
module fwd_sel_unit #(
  parameter int REG_AW         = 5,
  parameter int ZERO_REG_FIXED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_use_pc,
  input  logic              id_use_imm,
  input  logic              ext_stall,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              hazard_stall
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_ALT   = 2'b11;

  logic              ex_valid, ex_reg_write, ex_is_load, ex_use_pc, ex_use_imm;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              mem_valid, mem_reg_write, mem_is_load;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_reg_write;
  logic [REG_AW-1:0] wb_rd;

  // Load flag travels with the MEM slot for completeness; no select depends on it.
  logic unused_mem_is_load;
  assign unused_mem_is_load = mem_is_load;

  function automatic logic src_match(input logic              v,
                                     input logic              rw,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
    logic zero_src;
    zero_src = (ZERO_REG_FIXED != 0) && (src == '0);
    return v && rw && (rd == src) && !zero_src;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_is_load    <= 1'b0;
      ex_use_pc     <= 1'b0;
      ex_use_imm    <= 1'b0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_is_load   <= 1'b0;
      mem_rd        <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
    end else if (!ext_stall) begin
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_is_load   <= ex_is_load;
      mem_rd        <= ex_rd;
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_reg_write;
      wb_rd         <= mem_rd;
      if (flush || hazard_stall) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_is_load   <= 1'b0;
        ex_use_pc    <= 1'b0;
        ex_use_imm   <= 1'b0;
        ex_rs1       <= '0;
        ex_rs2       <= '0;
        ex_rd        <= '0;
      end else begin
        ex_valid     <= id_valid;
        ex_reg_write <= id_valid && id_reg_write;
        ex_is_load   <= id_valid && id_is_load;
        ex_use_pc    <= id_use_pc;
        ex_use_imm   <= id_use_imm;
        ex_rs1       <= id_rs1;
        ex_rs2       <= id_rs2;
        ex_rd        <= id_rd;
      end
    end
  end

  // Newest producer wins: the MEM slot is checked before the WB slot.
  always_comb begin
    sel_a = SEL_RF;
    sel_b = SEL_RF;
    if (ex_valid) begin
      if (ex_use_pc)
        sel_a = SEL_ALT;
      else if (src_match(mem_valid, mem_reg_write, mem_rd, ex_rs1))
        sel_a = SEL_EXMEM;
      else if (src_match(wb_valid, wb_reg_write, wb_rd, ex_rs1))
        sel_a = SEL_MEMWB;

      if (ex_use_imm)
        sel_b = SEL_ALT;
      else if (src_match(mem_valid, mem_reg_write, mem_rd, ex_rs2))
        sel_b = SEL_EXMEM;
      else if (src_match(wb_valid, wb_reg_write, wb_rd, ex_rs2))
        sel_b = SEL_MEMWB;
    end
  end

  // Only operands the decode instruction actually reads can cause a load-use stall.
  logic load_hit_rs1, load_hit_rs2;
  always_comb begin
    load_hit_rs1 = !id_use_pc  && src_match(ex_valid, ex_reg_write, ex_rd, id_rs1);
    load_hit_rs2 = !id_use_imm && src_match(ex_valid, ex_reg_write, ex_rd, id_rs2);
    hazard_stall = id_valid && ex_is_load && !flush && (load_hit_rs1 || load_hit_rs2);
  end

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed scoreboard bench for fwd_sel_unit: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_fwd_sel_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_reg_write = 1'b0, id_is_load = 1'b0, id_use_pc = 1'b0, id_use_imm = 1'b0;
  logic       ext_stall = 1'b0, flush = 1'b0;
  logic [1:0] sel_a, sel_b;
  logic       hazard_stall;

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld, pc, imm;
  } instr_t;

  typedef struct packed {
    logic [1:0] a, b;
    logic       st;
    int         tag;
  } exp_t;

  exp_t sb_q[$];

  fwd_sel_unit #(.REG_AW(5), .ZERO_REG_FIXED(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .ext_stall(ext_stall),
    .flush(flush), .sel_a(sel_a), .sel_b(sel_b), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  function automatic instr_t nop();
    return '0;
  endfunction
  function automatic instr_t alu(input int rd, input int rs1, input int rs2);
    return '{v:1'b1, rs1:5'(rs1), rs2:5'(rs2), rd:5'(rd), rw:1'b1, ld:1'b0, pc:1'b0, imm:1'b0};
  endfunction
  function automatic instr_t opi(input int rd, input int rs1, input int rs2f);
    return '{v:1'b1, rs1:5'(rs1), rs2:5'(rs2f), rd:5'(rd), rw:1'b1, ld:1'b0, pc:1'b0, imm:1'b1};
  endfunction
  function automatic instr_t lw(input int rd, input int rs1);
    return '{v:1'b1, rs1:5'(rs1), rs2:5'd0, rd:5'(rd), rw:1'b1, ld:1'b1, pc:1'b0, imm:1'b1};
  endfunction
  function automatic instr_t auipc(input int rd);
    return '{v:1'b1, rs1:5'd0, rs2:5'd0, rd:5'(rd), rw:1'b1, ld:1'b0, pc:1'b1, imm:1'b1};
  endfunction

  task automatic checkOutput(input string what, input int tag,
                             input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%b expected=%b", what, tag, act, exp);
    end
  endtask

  // Drive one decode cycle (called just after a rising edge) and record what
  // the outputs must show before the next rising edge.
  task automatic applyStimulus(input instr_t i, input logic fl, input logic es,
                               input logic rs, input logic [1:0] ea,
                               input logic [1:0] eb, input logic est);
    exp_t e;
    id_valid     = i.v;
    id_rs1       = i.rs1;
    id_rs2       = i.rs2;
    id_rd        = i.rd;
    id_reg_write = i.rw;
    id_is_load   = i.ld;
    id_use_pc    = i.pc;
    id_use_imm   = i.imm;
    flush        = fl;
    ext_stall    = es;
    rst          = rs;
    e.a = ea; e.b = eb; e.st = est; e.tag = cycle_no;
    sb_q.push_back(e);
    cycle_no++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checkOutput("sel_a", e.tag, sel_a, e.a);
      checkOutput("sel_b", e.tag, sel_b, e.b);
      checkOutput("hazard_stall", e.tag, {1'b0, hazard_stall}, {1'b0, e.st});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(nop(), 0, 0, 1, 2'b00, 2'b00, 0);            // reset held
    // back-to-back, one gap, two gaps
    applyStimulus(alu(5, 1, 2), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(6, 5, 5), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b10, 2'b10, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(5, 1, 2), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(6, 5, 5), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b01, 2'b01, 0);
    applyStimulus(alu(5, 1, 2), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(6, 5, 5), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b00, 2'b00, 0);
    // newest producer wins; x0 never forwards
    applyStimulus(alu(7, 1, 2), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(7, 3, 4), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(8, 7, 1), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b10, 2'b00, 0);
    applyStimulus(alu(0, 1, 2), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(9, 0, 0), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b00, 2'b00, 0);
    // load-use: one stall, one bubble, then the load is two slots ahead (WB)
    applyStimulus(lw(3, 1),     0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(4, 3, 1), 0, 0, 0, 2'b00, 2'b11, 1);
    applyStimulus(alu(4, 3, 1), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b01, 2'b00, 0);
    // immediate / PC operands; ignored rs2 field equal to a load rd
    applyStimulus(alu(1, 2, 2), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(opi(2, 1, 1), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(auipc(10),    0, 0, 0, 2'b10, 2'b11, 0);
    applyStimulus(lw(11, 2),    0, 0, 0, 2'b11, 2'b11, 0);
    applyStimulus(opi(12, 5, 11), 0, 0, 0, 2'b01, 2'b11, 0);
    applyStimulus(nop(),        0, 0, 0, 2'b00, 2'b11, 0);
    // flush of a decode load, then flush of a load-use consumer
    applyStimulus(nop(),          0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(lw(13, 1),      1, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(14, 13, 13), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(lw(13, 1),      0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(14, 13, 13), 1, 0, 0, 2'b00, 2'b11, 0);
    applyStimulus(nop(),          0, 0, 0, 2'b00, 2'b00, 0);
    // freeze for three cycles while forwarding
    applyStimulus(alu(15, 1, 2),   0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(16, 15, 15), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),           0, 1, 0, 2'b10, 2'b10, 0);
    applyStimulus(nop(),           0, 1, 0, 2'b10, 2'b10, 0);
    applyStimulus(nop(),           0, 1, 0, 2'b10, 2'b10, 0);
    applyStimulus(nop(),           0, 0, 0, 2'b10, 2'b10, 0);
    applyStimulus(nop(),           0, 0, 0, 2'b00, 2'b00, 0);
    // load-use stall stays asserted while frozen
    applyStimulus(lw(17, 1),       0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(18, 17, 2),  0, 1, 0, 2'b00, 2'b11, 1);
    applyStimulus(alu(18, 17, 2),  0, 1, 0, 2'b00, 2'b11, 1);
    applyStimulus(alu(18, 17, 2),  0, 0, 0, 2'b00, 2'b11, 1);
    applyStimulus(alu(18, 17, 2),  0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),           0, 0, 0, 2'b01, 2'b00, 0);
    // asynchronous reset with a valid forwarding EX slot
    applyStimulus(alu(19, 18, 18), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(alu(20, 19, 19), 0, 0, 0, 2'b01, 2'b01, 0);
    applyStimulus(alu(21, 20, 20), 0, 0, 1, 2'b00, 2'b00, 0);
    applyStimulus(alu(22, 20, 20), 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(nop(),           0, 0, 0, 2'b00, 2'b00, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
